seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-division scheduler that shares one 7-segment cathode bus among four common-anode digits. It snapshots a 4-digit BCD value once per frame and walks the anodes in fixed slots. Each slot opens with a dead-time blanking interval to suppress ghosting. It sits between the BCD counter datapath and the board anode/cathode pins, replacing ad-hoc anode sequencing.

Parameters:
- DIV, 6250000: clock cycles per digit slot; legal range ≥ 2.
- BLANK, 1000: dead-time cycles at the start of each slot; legal range 0 ≤ BLANK < DIV.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable.
- digits_i, input, 16: BCD digits; [3:0] is digit 0 (units), [15:12] is digit 3 (thousands).
- lzb_i, input, 1: leading-zero blanking enable.
- an_o, output, 4: anodes, active-low; an_o[0] is digit 0.
- seg_o, output, 7: cathodes, active-high; bit 6 = a, bit 0 = g.
- idx_o, output, 2: slot index currently driven.
- frame_o, output, 1: one-cycle end-of-frame pulse.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous):
  - an_o = 4'b1111, seg_o = 7'b0000000, idx_o = 0, frame_o = 0.
  - State IDLE; snapshot cleared to 0; slot counter = 0.
- States:
  - IDLE: outputs off.
  - BLANK: an_o = 1111, seg_o = 0.
  - DRIVE: one anode low, decoded segments on seg_o.
- Entry from IDLE: at the edge where en is sampled high (edge T):
  - go to BLANK (or straight to DRIVE if BLANK = 0) with idx = 0;
  - capture digits_i into the snapshot.
- Slot timing, slot k starting at edge S:
  - BLANK occupies edges S .. S+BLANK−1.
  - At edge S+BLANK, outputs switch to an_o = ~(1 << k) and seg_o = decode(snapshot digit k). They hold until edge S+DIV.
  - At edge S+DIV, idx advances k → k+1, wrapping 3 → 0. The slot counter runs 0 .. DIV−1.
- Snapshot: digits_i is re-captured only on entry to slot 0. Mid-frame changes to digits_i are not displayed until the next frame (no tearing).
- frame_o: high for exactly the one cycle that is the last cycle of slot 3 DRIVE, registered from edge T+4·DIV−1.
- Decode table (seg_o values):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - codes 10–15 = 0000001 (dash)
- Leading-zero blanking, when lzb_i = 1:
  - Digit k ∈ {3, 2, 1} shows seg_o = 0 if its snapshot digit and every higher snapshot digit are 0.
  - The anode is still asserted.
  - Digit 0 is never blanked.
  - lzb_i is sampled with the snapshot.
- en deasserted: at the next edge go to IDLE regardless of slot position.
  - Outputs off, idx_o = 0, slot counter = 0, frame_o = 0.
  - No partial-frame frame_o pulse.
- en re-asserted: restarts from slot 0 with a fresh snapshot, exactly as at first entry.
- Invariants:
  - At most one an_o bit is low at any time.
  - seg_o = 0 whenever an_o = 1111.
- Width rules: slot counter is $clog2(DIV) bits; its terminal compare is at DIV−1 and it never overflows.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_0 .. SEG_9, SEG_DASH, SEG_OFF, AN_OFF constants;
  - state enum {IDLE, BLANK, DRIVE}.
- Sub-module seg_decode: combinational 4-bit BCD → 7-bit pattern per the table above. It is reused by the counter datapath.
- Scan FSM, slot counter and snapshot register all live in seg_scan_ctrl.

Test Plan (DIV = 8, BLANK = 2):
1. rst_n low mid-DRIVE, asynchronously between edges → an_o = 1111, seg_o = 0, idx_o = 0 immediately, without waiting for a clock edge.
2. en = 1 at T, digits_i = 16'h1234, lzb_i = 0:
   - T..T+1: an_o = 1111.
   - T+2..T+7: an_o = 1110, seg_o = 0110011.
   - T+10: an_o = 1101, seg_o = 1111001.
   - slot 3 shows 0110000.
   - frame_o high only in cycle T+31.
3. digits_i changed to 16'h9999 at T+12 → slots 1–3 of the current frame still show 3, 2, 1; digit 0 shows 1111011 from T+34.
4. digits_i = 16'h0040, lzb_i = 1 → digits 3 and 2 show seg_o = 0 with anodes 0111 and 1011 asserted; digit 1 shows 0110011; digit 0 shows 1111110. Repeat with 16'h0000 → only digit 0 lit (1111110).
5. digits_i = 16'h00A0 → digit 1 slot shows 0000001.
6. en dropped at T+13 (slot 1 DRIVE) → from T+14: an_o = 1111, idx_o = 0, no frame_o. Re-enable at T+20 → slot 0 BLANK at T+20..T+21, fresh snapshot taken.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for 7-segment display logic.
package seg_pkg;

  // Cathode patterns, active-high, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // All anodes released (active-low)
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module seg_decode (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  import seg_pkg::*;

  // Table lookup of the segment pattern for one BCD code
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-slot dead time,
// frame-coherent digit snapshot and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIV   = 6250000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits_i,
  input  logic        lzb_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic [1:0]  idx_o,
  output logic        frame_o
);
  import seg_pkg::*;

  localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK);

  seg_pkg::state_t state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic [15:0]     snap_reg, snap_next;
  logic            lzb_reg, lzb_next;
  logic [3:0]      an_reg;
  logic [6:0]      seg_reg;
  logic            frame_reg;

  logic [3:0]      digit_next;
  logic [6:0]      dec_seg;
  logic            lz_blank;
  logic            drive_next;

  // Next slot position, state and snapshot; the snapshot is only refreshed
  // when entering slot 0 so a frame never mixes old and new digits.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    snap_next  = snap_reg;
    lzb_next   = lzb_reg;
    if (!en) begin
      state_next = seg_pkg::IDLE;
      cnt_next   = '0;
      idx_next   = 2'd0;
    end else if (state_reg == seg_pkg::IDLE) begin
      cnt_next   = '0;
      idx_next   = 2'd0;
      snap_next  = digits_i;
      lzb_next   = lzb_i;
      state_next = (CNT_BLANK == '0) ? seg_pkg::DRIVE : seg_pkg::BLANK;
    end else begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          snap_next = digits_i;
          lzb_next  = lzb_i;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      state_next = (cnt_next < CNT_BLANK) ? seg_pkg::BLANK : seg_pkg::DRIVE;
    end
  end

  // Select the snapshot digit for the upcoming slot and decide whether it is
  // a leading zero (it and every more significant digit are zero)
  always_comb begin
    digit_next = snap_next[3:0];
    lz_blank   = 1'b0;
    case (idx_next)
      2'd0: begin
        digit_next = snap_next[3:0];
        lz_blank   = 1'b0;
      end
      2'd1: begin
        digit_next = snap_next[7:4];
        lz_blank   = (snap_next[15:4] == 12'd0);
      end
      2'd2: begin
        digit_next = snap_next[11:8];
        lz_blank   = (snap_next[15:8] == 8'd0);
      end
      default: begin
        digit_next = snap_next[15:12];
        lz_blank   = (snap_next[15:12] == 4'd0);
      end
    endcase
    lz_blank   = lz_blank & lzb_next;
    drive_next = (state_next == seg_pkg::DRIVE);
  end

  seg_decode u_decode (
    .bcd_i (digit_next),
    .seg_o (dec_seg)
  );

  // State registers plus registered pin drivers derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= seg_pkg::IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      snap_reg  <= 16'd0;
      lzb_reg   <= 1'b0;
      an_reg    <= AN_OFF;
      seg_reg   <= SEG_OFF;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      snap_reg  <= snap_next;
      lzb_reg   <= lzb_next;
      an_reg    <= drive_next ? ~(4'b0001 << idx_next) : AN_OFF;
      seg_reg   <= (drive_next && !lz_blank) ? dec_seg : SEG_OFF;
      frame_reg <= drive_next && (idx_next == 2'd3) && (cnt_next == CNT_LAST);
    end
  end

  assign an_o    = an_reg;
  assign seg_o   = seg_reg;
  assign idx_o   = idx_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV = 8, BLANK = 2.
module tb_seg_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam logic [13:0] OFF = {4'b1111, 7'b0000000, 2'd0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits_i = 16'h0000;
  logic        lzb_i = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic [1:0]  idx_o;
  logic        frame_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .digits_i (digits_i),
    .lzb_i    (lzb_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .idx_o    (idx_o),
    .frame_o  (frame_o)
  );

  typedef struct packed {
    logic [15:0]     digits;
    logic            lzb;
    logic [3:0][6:0] seg;   // expected pattern per slot, [0] = digit 0
  } vec_t;

  vec_t vecs [6];

  // Expected {an, seg, idx, frame} for cycle c counted from entry edge T
  function automatic logic [13:0] expect_at(input int c, input logic [3:0][6:0] segs);
    int slot;
    int ph;
    logic [3:0] an;
    slot = (c / DIV) % 4;
    ph   = c % DIV;
    an   = 4'b1111;
    an[slot] = 1'b0;
    if (ph < BLANK)
      return {4'b1111, 7'b0000000, 2'(slot), 1'b0};
    return {an, segs[slot], 2'(slot), (slot == 3 && ph == DIV - 1)};
  endfunction

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {an_o, seg_o, idx_o, frame_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b idx=%0d frame=%b, want an=%b seg=%b idx=%0d frame=%b",
               name, act[13:10], act[9:3], act[2:1], act[0],
               exp[13:10], exp[9:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Put the DUT into IDLE, then arm en with new digits so the next edge is T
  task automatic arm(input logic [15:0] d, input logic l);
    en = 1'b0;
    tick();
    chk("idle_before_arm", OFF);
    digits_i = d;
    lzb_i    = l;
    en       = 1'b1;
  endtask

  logic [3:0][6:0] s1234, s9999, s5678;
  int err_start;

  initial begin
    s1234 = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    s9999 = {4{7'b1111011}};
    s5678 = {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};

    vecs[0] = '{digits: 16'h1234, lzb: 1'b0, seg: s1234};
    vecs[1] = '{digits: 16'h0040, lzb: 1'b1,
                seg: {7'b0000000, 7'b0000000, 7'b0110011, 7'b1111110}};
    vecs[2] = '{digits: 16'h0000, lzb: 1'b1,
                seg: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[3] = '{digits: 16'h00A0, lzb: 1'b0,
                seg: {7'b1111110, 7'b1111110, 7'b0000001, 7'b1111110}};
    vecs[4] = '{digits: 16'h0905, lzb: 1'b1,
                seg: {7'b0000000, 7'b1111011, 7'b1111110, 7'b1011011}};
    vecs[5] = '{digits: 16'h8765, lzb: 1'b1, seg: s5678 ^ s5678 |
                {7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011}};

    // Reset state
    #12;
    chk("reset_state", OFF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", OFF);
    $display("reset: an=%b seg=%b idx=%0d frame=%b", an_o, seg_o, idx_o, frame_o);

    // Table-driven full frames
    for (int i = 0; i < 6; i++) begin
      err_start = errors;
      arm(vecs[i].digits, vecs[i].lzb);
      for (int c = 0; c < 4 * DIV; c++) begin
        tick();
        chk($sformatf("vec%0d_c%0d", i, c), expect_at(c, vecs[i].seg));
      end
      $display("vector %0d digits=%h lzb=%b errors_here=%0d",
               i, vecs[i].digits, vecs[i].lzb, errors - err_start);
    end

    // Mid-frame digit change is held back until the next frame
    err_start = errors;
    arm(16'h1234, 1'b0);
    for (int c = 0; c < 4 * DIV + 4; c++) begin
      tick();
      chk($sformatf("snap_c%0d", c), expect_at(c, (c < 4 * DIV) ? s1234 : s9999));
      if (c == 11) digits_i = 16'h9999;
    end
    $display("snapshot sequence errors_here=%0d", errors - err_start);

    // en dropped in slot 1 DRIVE, then re-enabled with new digits
    err_start = errors;
    arm(16'h1234, 1'b0);
    for (int c = 0; c <= 13; c++) begin
      tick();
      chk($sformatf("drop_c%0d", c), expect_at(c, s1234));
    end
    en = 1'b0;
    for (int c = 14; c <= 19; c++) begin
      tick();
      chk($sformatf("drop_off_c%0d", c), OFF);
    end
    digits_i = 16'h5678;
    en       = 1'b1;
    for (int c = 0; c < 4 * DIV; c++) begin
      tick();
      chk($sformatf("reen_c%0d", c), expect_at(c, s5678));
    end
    $display("enable drop/restart errors_here=%0d", errors - err_start);

    // Asynchronous reset in the middle of a DRIVE cycle
    err_start = errors;
    arm(16'h1234, 1'b0);
    for (int c = 0; c <= 4; c++) begin
      tick();
      chk($sformatf("arst_pre_c%0d", c), expect_at(c, s1234));
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset_immediate", OFF);
    @(negedge clk);
    chk("async_reset_held", OFF);
    en    = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("after_async_reset", OFF);
    $display("async reset errors_here=%0d", errors - err_start);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
